// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared widths, pipeline wait-state encoding and helpers
//
// Purpose:
//    Common definitions for the MEM/WB stage and any future pipeline wait logic
//    (for example an IF-side instruction-memory wait controller).
//
// Contents:
//    WORD_LEN_DEF           default datapath width
//    REG_FILE_ADDR_LEN_DEF  default register-file index width
//    TIMEOUT_DEF            default maximum stall cycles before mem_err
//    pl_state_e             pipeline wait FSM state (PL_IDLE / PL_WAIT)
//    is_access()            true when the instruction touches data memory
package mem_wb_stage_pkg;

   localparam int WORD_LEN_DEF          = 32;
   localparam int REG_FILE_ADDR_LEN_DEF = 5;
   localparam int TIMEOUT_DEF           = 16;

   // Encoding is fixed so other wait controllers can share it.
   typedef enum logic {
      PL_IDLE = 1'b0,
      PL_WAIT = 1'b1
   } pl_state_e;

   function automatic logic is_access(input logic rd_en, input logic wr_en);
      return rd_en | wr_en;
   endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM-stage to register-file bus of the MEM/WB stage
//
// Purpose:
//    Bundles the control/data arriving from the MEM stage together with the
//    register-file write port and pipeline status returned by the MEM/WB stage.
//
// Signals:
//    WB_EN_in     MEM -> stage   instruction in MEM writes a register
//    MEM_R_EN     MEM -> stage   instruction in MEM is a load
//    MEM_W_EN     MEM -> stage   instruction in MEM is a store
//    dest_in      MEM -> stage   destination register index
//    ALU_res      MEM -> stage   ALU result / address
//    dataMem_out  MEM -> stage   load data, valid when mem_ready=1
//    mem_ready    MEM -> stage   data memory completes its access this cycle
//    WB_EN        stage -> RF    register-file write enable
//    dest         stage -> RF    register-file write index
//    WB_value     stage -> RF    register-file write data
//    mem_stall    stage -> pipe  freeze upstream pipeline registers
//    mem_err      stage -> pipe  sticky data-memory timeout flag
//
// Modports:
//    master  the upstream side (MEM stage / environment)
//    slave   the MEM/WB stage itself
interface mem_wb_stage_if
   import mem_wb_stage_pkg::*;
#(
   parameter int WORD_LEN     = WORD_LEN_DEF,
   parameter int REG_ADDR_LEN = REG_FILE_ADDR_LEN_DEF
);

   logic                    WB_EN_in;
   logic                    MEM_R_EN;
   logic                    MEM_W_EN;
   logic [REG_ADDR_LEN-1:0] dest_in;
   logic [WORD_LEN-1:0]     ALU_res;
   logic [WORD_LEN-1:0]     dataMem_out;
   logic                    mem_ready;

   logic                    WB_EN;
   logic [REG_ADDR_LEN-1:0] dest;
   logic [WORD_LEN-1:0]     WB_value;
   logic                    mem_stall;
   logic                    mem_err;

   modport master (
      output WB_EN_in, MEM_R_EN, MEM_W_EN, dest_in, ALU_res, dataMem_out, mem_ready,
      input  WB_EN, dest, WB_value, mem_stall, mem_err
   );

   modport slave (
      input  WB_EN_in, MEM_R_EN, MEM_W_EN, dest_in, ALU_res, dataMem_out, mem_ready,
      output WB_EN, dest, WB_value, mem_stall, mem_err
   );

endinterface

// File: rtl/mem_wb_stage_mem_wait.sv
// rtl/mem_wb_stage_mem_wait.sv - data-memory wait controller with timeout
//
// Purpose:
//    Tracks an outstanding data-memory access, stalls the pipeline while the
//    memory is not ready and abandons the access after TIMEOUT stall cycles,
//    raising a sticky error flag.
//
// Ports:
//    clk           rising-edge clock
//    rst           asynchronous active-high reset
//    access_i      instruction in MEM is a load or store
//    mem_ready_i   data memory completes the access this cycle
//    mem_stall_o   freeze upstream stages (combinational)
//    abandon_o     this cycle is the timeout exit of a waiting access
//    mem_err_o     sticky timeout flag (registered)
module mem_wait_fsm
   import mem_wb_stage_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic access_i,
   input  logic mem_ready_i,
   output logic mem_stall_o,
   output logic abandon_o,
   output logic mem_err_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   pl_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             mem_err_q;
   logic             at_limit;

   // The counter holds how many stall cycles the current access has already
   // consumed; at the limit the cycle becomes the abandon cycle instead of a
   // further stall.
   assign at_limit = (state_q == PL_WAIT) && (cnt_q == CNT_LIMIT);

   // Gated by rst so an asynchronous reset releases the pipeline in the same
   // instant even if the MEM stage still presents its access.
   assign mem_stall_o = !rst && access_i && !mem_ready_i && !at_limit;
   assign abandon_o   = at_limit && !mem_ready_i;
   assign mem_err_o   = mem_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= PL_IDLE;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else if (state_q == PL_IDLE) begin
         if (access_i && !mem_ready_i) begin
            state_q <= PL_WAIT;
            cnt_q   <= CNT_ONE;
         end
      end else begin
         if (mem_ready_i) begin
            state_q <= PL_IDLE;
            cnt_q   <= '0;
         end else if (at_limit) begin
            state_q   <= PL_IDLE;
            cnt_q     <= '0;
            mem_err_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, writeback mux and memory wait control
//
// Purpose:
//    Sits directly downstream of the MEM stage. Captures the MEM stage's
//    control/data every cycle into the MEM/WB register, drives the register
//    file write port and stalls the pipeline while a data-memory access is
//    outstanding. An access that never completes is abandoned after TIMEOUT
//    stall cycles and flagged on mem_err.
//
// Ports:
//    clk      rising-edge clock
//    rst      asynchronous active-high reset
//    mem_if   slave side of mem_wb_stage_if (MEM-stage inputs, RF write port,
//             mem_stall, mem_err)
//
// Parameters:
//    WORD_LEN      datapath width
//    REG_ADDR_LEN  register-file index width
//    TIMEOUT       maximum stall cycles before mem_err (>= 1)
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int WORD_LEN     = WORD_LEN_DEF,
   parameter int REG_ADDR_LEN = REG_FILE_ADDR_LEN_DEF,
   parameter int TIMEOUT      = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   mem_wb_stage_if.slave mem_if
);

   logic access;
   logic mem_stall;
   logic abandon;
   logic mem_err;

   logic                    wb_en_q, wb_en_d;
   logic [REG_ADDR_LEN-1:0] dest_q,  dest_d;
   logic [WORD_LEN-1:0]     alu_q,   alu_d;
   logic [WORD_LEN-1:0]     mem_q,   mem_d;
   logic                    sel_q,   sel_d;

   assign access = is_access(mem_if.MEM_R_EN, mem_if.MEM_W_EN);

   mem_wait_fsm #(
      .TIMEOUT (TIMEOUT)
   ) u_mem_wait (
      .clk         (clk),
      .rst         (rst),
      .access_i    (access),
      .mem_ready_i (mem_if.mem_ready),
      .mem_stall_o (mem_stall),
      .abandon_o   (abandon),
      .mem_err_o   (mem_err)
   );

   // While stalled only the write enable is cleared (bubble); the data fields
   // hold so WB_value stays stable. On the abandon cycle the instruction still
   // leaves MEM but must not write the register file.
   always_comb begin
      wb_en_d = wb_en_q;
      dest_d  = dest_q;
      alu_d   = alu_q;
      mem_d   = mem_q;
      sel_d   = sel_q;
      if (mem_stall) begin
         wb_en_d = 1'b0;
      end else begin
         wb_en_d = mem_if.WB_EN_in && !abandon;
         dest_d  = mem_if.dest_in;
         alu_d   = mem_if.ALU_res;
         mem_d   = mem_if.dataMem_out;
         sel_d   = mem_if.MEM_R_EN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en_q <= 1'b0;
         dest_q  <= '0;
         alu_q   <= '0;
         mem_q   <= '0;
         sel_q   <= 1'b0;
      end else begin
         wb_en_q <= wb_en_d;
         dest_q  <= dest_d;
         alu_q   <= alu_d;
         mem_q   <= mem_d;
         sel_q   <= sel_d;
      end
   end

   assign mem_if.WB_EN     = wb_en_q;
   assign mem_if.dest      = dest_q;
   assign mem_if.WB_value  = sel_q ? mem_q : alu_q;
   assign mem_if.mem_stall = mem_stall;
   assign mem_if.mem_err   = mem_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

   localparam int WL = 32;
   localparam int AL = 5;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   mem_wb_stage_if #(.WORD_LEN(WL), .REG_ADDR_LEN(AL)) bus ();

   mem_wb_stage #(
      .WORD_LEN     (WL),
      .REG_ADDR_LEN (AL),
      .TIMEOUT      (TO)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .mem_if (bus)
   );

   always #5 clk = ~clk;

   // Reference model: what the register file should see, tracked per
   // instruction rather than per state. m_waited counts stall cycles already
   // spent on the access currently sitting in MEM.
   logic          m_wb_en  = 1'b0;
   logic [AL-1:0] m_dest   = '0;
   logic [WL-1:0] m_value  = '0;
   logic          m_err    = 1'b0;
   int            m_waited = 0;

   function automatic logic exp_stall();
      logic acc;
      acc = bus.MEM_R_EN | bus.MEM_W_EN;
      return !rst && acc && !bus.mem_ready && (m_waited < TO);
   endfunction

   always @(posedge clk or posedge rst) begin
      logic acc;
      logic aband;
      if (rst) begin
         m_wb_en  = 1'b0;
         m_dest   = '0;
         m_value  = '0;
         m_err    = 1'b0;
         m_waited = 0;
      end else if (exp_stall()) begin
         m_wb_en  = 1'b0;
         m_waited = m_waited + 1;
      end else begin
         acc   = bus.MEM_R_EN | bus.MEM_W_EN;
         aband = acc && !bus.mem_ready && (m_waited == TO);
         if (aband) m_err = 1'b1;
         m_wb_en  = bus.WB_EN_in && !aband;
         m_dest   = bus.dest_in;
         m_value  = bus.MEM_R_EN ? bus.dataMem_out : bus.ALU_res;
         m_waited = 0;
      end
   end

   task automatic chk(input string name, input logic [WL-1:0] got, input logic [WL-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Continuous comparison against the model, mid-cycle.
   always @(negedge clk) begin
      chk("model_stall", WL'(bus.mem_stall), WL'(exp_stall()));
      chk("model_wb_en", WL'(bus.WB_EN),     WL'(m_wb_en));
      chk("model_dest",  WL'(bus.dest),      WL'(m_dest));
      chk("model_value", bus.WB_value,       m_value);
      chk("model_err",   WL'(bus.mem_err),   WL'(m_err));
   end

   task automatic drive(input logic we, input logic r, input logic w, input logic [AL-1:0] d,
                        input logic [WL-1:0] alu, input logic [WL-1:0] data, input logic rdy);
      bus.WB_EN_in    = we;
      bus.MEM_R_EN    = r;
      bus.MEM_W_EN    = w;
      bus.dest_in     = d;
      bus.ALU_res     = alu;
      bus.dataMem_out = data;
      bus.mem_ready   = rdy;
   endtask

   task automatic cyc(input logic we, input logic r, input logic w, input logic [AL-1:0] d,
                      input logic [WL-1:0] alu, input logic [WL-1:0] data, input logic rdy);
      @(posedge clk);
      #2;
      drive(we, r, w, d, alu, data, rdy);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic chk_wb(input string tag, input logic en, input logic [AL-1:0] d, input logic [WL-1:0] v);
      chk({tag, "_wb_en"}, WL'(bus.WB_EN), WL'(en));
      chk({tag, "_dest"},  WL'(bus.dest),  WL'(d));
      chk({tag, "_value"}, bus.WB_value,   v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk_wb("reset", 1'b0, 5'd0, 32'h0);
      chk("reset_stall", WL'(bus.mem_stall), 32'h0);
      chk("reset_err",   WL'(bus.mem_err),   32'h0);
      rst = 1'b0;

      // 1: plain ALU op, memory data must be ignored
      cyc(1'b1, 1'b0, 1'b0, 5'd5, 32'h2A, 32'h5555, 1'b0);
      #1 chk("t1_stall", WL'(bus.mem_stall), 32'h0);
      idle();
      #1 chk_wb("t1", 1'b1, 5'd5, 32'h2A);

      // 2: load completing in the same cycle
      cyc(1'b1, 1'b1, 1'b0, 5'd7, 32'h100, 32'hDEAD, 1'b1);
      #1 chk("t2_stall", WL'(bus.mem_stall), 32'h0);
      idle();
      #1 chk_wb("t2", 1'b1, 5'd7, 32'hDEAD);

      // 3: load with three wait cycles
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 5'd9, 32'h200, 32'h0, 1'b0);
         #1 chk("t3_stall", WL'(bus.mem_stall), 32'h1);
         chk("t3_wb_en_bubble", WL'(bus.WB_EN), 32'h0);
      end
      cyc(1'b1, 1'b1, 1'b0, 5'd9, 32'h200, 32'hBEEF, 1'b1);
      #1 chk("t3_stall_done", WL'(bus.mem_stall), 32'h0);
      chk("t3_wb_en_last_bubble", WL'(bus.WB_EN), 32'h0);
      idle();
      #1 chk_wb("t3", 1'b1, 5'd9, 32'hBEEF);

      // 4: store that never completes -> timeout after TO stall cycles
      for (int i = 0; i < TO; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 5'd3, 32'h300, 32'h0, 1'b0);
         #1 chk("t4_stall", WL'(bus.mem_stall), 32'h1);
         chk("t4_err_pending", WL'(bus.mem_err), 32'h0);
      end
      cyc(1'b0, 1'b0, 1'b1, 5'd3, 32'h300, 32'h0, 1'b0);
      #1 chk("t4_stall_drop", WL'(bus.mem_stall), 32'h0);
      idle();
      #1 chk("t4_err", WL'(bus.mem_err), 32'h1);
      chk("t4_wb_en", WL'(bus.WB_EN), 32'h0);
      idle();
      #1 chk("t4_err_sticky", WL'(bus.mem_err), 32'h1);

      // store with WB_EN_in set still writes the ALU value; ready without access is ignored
      cyc(1'b1, 1'b0, 1'b1, 5'd4, 32'h444, 32'h999, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h7, 1'b1);
      #1 chk_wb("store_wb", 1'b1, 5'd4, 32'h444);
      chk("ready_no_access_stall", WL'(bus.mem_stall), 32'h0);

      // 5: asynchronous reset while waiting
      cyc(1'b1, 1'b1, 1'b0, 5'd6, 32'h10, 32'h0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 5'd6, 32'h10, 32'h0, 1'b0);
      #1 chk("t5_stall_before", WL'(bus.mem_stall), 32'h1);
      #1 rst = 1'b1;
      #1 chk("t5_stall_rst", WL'(bus.mem_stall), 32'h0);
      chk("t5_wb_en_rst", WL'(bus.WB_EN),   32'h0);
      chk("t5_err_rst",   WL'(bus.mem_err), 32'h0);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      @(negedge clk);
      #1 rst = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 5'd8, 32'h77, 32'h0, 1'b0);
      idle();
      #1 chk_wb("t5_after", 1'b1, 5'd8, 32'h77);

      // 6: back-to-back loads, one wait cycle each
      cyc(1'b1, 1'b1, 1'b0, 5'd1, 32'hA1, 32'h0, 1'b0);
      #1 chk("t6_l1_stall", WL'(bus.mem_stall), 32'h1);
      cyc(1'b1, 1'b1, 1'b0, 5'd1, 32'hA1, 32'h1111, 1'b1);
      #1 chk("t6_l1_done", WL'(bus.mem_stall), 32'h0);
      cyc(1'b1, 1'b1, 1'b0, 5'd2, 32'hA2, 32'h0, 1'b0);
      #1 chk("t6_l2_stall", WL'(bus.mem_stall), 32'h1);
      chk_wb("t6_first", 1'b1, 5'd1, 32'h1111);
      cyc(1'b1, 1'b1, 1'b0, 5'd2, 32'hA2, 32'h2222, 1'b1);
      #1 chk("t6_l2_done", WL'(bus.mem_stall), 32'h0);
      chk("t6_bubble", WL'(bus.WB_EN), 32'h0);
      idle();
      #1 chk_wb("t6_second", 1'b1, 5'd2, 32'h2222);
      idle();
      idle();

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
